// File: rtl/regfile_scoreboard.sv
// Register file for the pipelined MIPS core: two combinational read ports, one write port,
// entry 0 hardwired to zero, a sequential clear sweep after reset, optional write-to-read
// bypass and a per-register pending-write scoreboard used by decode for RAW stalls.
module regfile_scoreboard #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned BYPASS = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    // writeback port
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    // read ports
    input  logic [ADDR_W-1:0] raddr1_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [DATA_W-1:0] rdata2_o,
    // scoreboard
    input  logic              issue_valid_i,
    input  logic [ADDR_W-1:0] issue_addr_i,
    output logic              busy1_o,
    output logic              busy2_o,
    output logic              ready_o
);

    localparam int unsigned       DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
    localparam bit                BypassEn = (BYPASS != 0);

    typedef enum logic {
        StInit,
        StReady
    } state_e;

    state_e               state_q;
    logic [ADDR_W-1:0]    init_cnt_q;
    logic                 ready_q;
    logic [DEPTH-1:0]     pending_q;
    logic [DEPTH-1:0]     pending_d;
    logic [DATA_W-1:0]    mem_q [DEPTH];

    logic                 sweep_en;
    logic                 wr_en;
    logic                 issue_en;
    logic                 fwd1;
    logic                 fwd2;

    // Architectural writes and issues only count once the sweep has finished.
    assign sweep_en = (state_q == StInit) && !rst_i;
    assign wr_en    = ready_q && !rst_i && we_i && (waddr_i != '0);
    assign issue_en = ready_q && !rst_i && issue_valid_i && (issue_addr_i != '0);

    // Same-cycle writeback match per read port; only meaningful when bypass is built in.
    assign fwd1 = BypassEn && we_i && (waddr_i == raddr1_i);
    assign fwd2 = BypassEn && we_i && (waddr_i == raddr2_i);

    // Init/ready FSM: sweep every entry once after reset, then stay ready until the next reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StInit;
            init_cnt_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StInit: begin
                    if (init_cnt_q == LastAddr) begin
                        // Counter parks on the last entry instead of wrapping.
                        state_q <= StReady;
                        ready_q <= 1'b1;
                    end else begin
                        init_cnt_q <= init_cnt_q + 1'b1;
                    end
                end
                StReady: begin
                    state_q <= StReady;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q    <= StInit;
                    init_cnt_q <= '0;
                    ready_q    <= 1'b0;
                end
            endcase
        end
    end

    // Storage: the sweep clears one entry per cycle; afterwards the writeback port owns it.
    always_ff @(posedge clk_i) begin
        if (sweep_en) begin
            mem_q[init_cnt_q] <= '0;
        end else if (wr_en) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Scoreboard next state: writeback clears, issue sets, and issue wins on a collision.
    always_comb begin
        pending_d = pending_q;
        if (wr_en) begin
            pending_d[waddr_i] = 1'b0;
        end
        if (issue_en) begin
            pending_d[issue_addr_i] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // Scoreboard state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Read port 1: zero until ready and for entry 0, then bypass or array contents.
    always_comb begin
        rdata1_o = '0;
        if (ready_q && (raddr1_i != '0)) begin
            if (fwd1) begin
                rdata1_o = wdata_i;
            end else begin
                rdata1_o = mem_q[raddr1_i];
            end
        end
    end

    // Read port 2: same selection as port 1.
    always_comb begin
        rdata2_o = '0;
        if (ready_q && (raddr2_i != '0)) begin
            if (fwd2) begin
                rdata2_o = wdata_i;
            end else begin
                rdata2_o = mem_q[raddr2_i];
            end
        end
    end

    // Busy reflects registered pending state; a forwarded writeback resolves the hazard now.
    always_comb begin
        busy1_o = ready_q && pending_q[raddr1_i] && (raddr1_i != '0) && !fwd1;
        busy2_o = ready_q && pending_q[raddr2_i] && (raddr2_i != '0) && !fwd2;
    end

    assign ready_o = ready_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: one bypassing and one non-bypassing instance share all stimulus.
module tb_regfile_scoreboard;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic        issue_valid;
    logic [4:0]  issue_addr;

    logic [31:0] rdata1_b, rdata2_b, rdata1_n, rdata2_n;
    logic        busy1_b, busy2_b, busy1_n, busy2_n;
    logic        ready_b, ready_n;

    int n_vec;
    int n_err;
    int lat;

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) u_dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .we_i          (we),
        .waddr_i       (waddr),
        .wdata_i       (wdata),
        .raddr1_i      (raddr1),
        .raddr2_i      (raddr2),
        .rdata1_o      (rdata1_b),
        .rdata2_o      (rdata2_b),
        .issue_valid_i (issue_valid),
        .issue_addr_i  (issue_addr),
        .busy1_o       (busy1_b),
        .busy2_o       (busy2_b),
        .ready_o       (ready_b)
    );

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) u_dut_nb (
        .clk_i         (clk),
        .rst_i         (rst),
        .we_i          (we),
        .waddr_i       (waddr),
        .wdata_i       (wdata),
        .raddr1_i      (raddr1),
        .raddr2_i      (raddr2),
        .rdata1_o      (rdata1_n),
        .rdata2_o      (rdata2_n),
        .issue_valid_i (issue_valid),
        .issue_addr_i  (issue_addr),
        .busy1_o       (busy1_n),
        .busy2_o       (busy2_n),
        .ready_o       (ready_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count cycles until ready on the bypass instance, bounded.
    task automatic wait_ready(output int n);
        n = 0;
        while (!ready_b && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        we    = 1'b1;
        waddr = a;
        wdata = d;
        tick();
        we    = 1'b0;
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst         = 1'b1;
        we          = 1'b0;
        waddr       = '0;
        wdata       = '0;
        raddr1      = '0;
        raddr2      = '0;
        issue_valid = 1'b0;
        issue_addr  = '0;

        // 1: reset, sweep latency, writes/issues ignored during INIT
        tick();
        rst = 1'b0;
        check("rst_ready", 32'(ready_b), 32'd0);
        check("rst_busy1", 32'(busy1_b), 32'd0);
        we          = 1'b1;
        waddr       = 5'd3;
        wdata       = 32'hFFFF_FFFF;
        issue_valid = 1'b1;
        issue_addr  = 5'd4;
        raddr1      = 5'd3;
        raddr2      = 5'd4;
        #1;
        check("init_rdata1", rdata1_b, 32'h0);
        repeat (31) tick();
        check("init_ready_31", 32'(ready_b), 32'd0);
        we          = 1'b0;
        issue_valid = 1'b0;
        tick();
        check("init_ready_32", 32'(ready_b), 32'd1);
        check("init_ready_32_nb", 32'(ready_n), 32'd1);
        #1;
        check("init_busy_ignored", 32'(busy2_b), 32'd0);
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(31 - i);
            #1;
            check($sformatf("clear_r1_%0d", i), rdata1_b, 32'h0);
            check($sformatf("clear_r2_%0d", 31 - i), rdata2_n, 32'h0);
        end

        // 2: basic write/read, write to entry 0 discarded
        do_write(5'd5, 32'hDEAD_BEEF);
        raddr1 = 5'd5;
        #1;
        check("wr5_r1", rdata1_b, 32'hDEAD_BEEF);
        check("wr5_r1_nb", rdata1_n, 32'hDEAD_BEEF);
        we     = 1'b1;
        waddr  = 5'd0;
        wdata  = 32'h0000_1234;
        raddr2 = 5'd0;
        #1;
        check("wr0_same", rdata2_b, 32'h0);
        tick();
        we = 1'b0;
        #1;
        check("wr0_after", rdata2_b, 32'h0);
        check("wr0_after_nb", rdata2_n, 32'h0);

        // 3: same-cycle bypass on both ports
        do_write(5'd7, 32'h1111_2222);
        we     = 1'b1;
        waddr  = 5'd7;
        wdata  = 32'hA5A5_A5A5;
        raddr1 = 5'd7;
        raddr2 = 5'd7;
        #1;
        check("byp_r1", rdata1_b, 32'hA5A5_A5A5);
        check("byp_r2", rdata2_b, 32'hA5A5_A5A5);
        check("nobyp_r1", rdata1_n, 32'h1111_2222);
        check("nobyp_r2", rdata2_n, 32'h1111_2222);
        tick();
        we = 1'b0;
        #1;
        check("byp_after", rdata1_b, 32'hA5A5_A5A5);
        check("nobyp_after", rdata2_n, 32'hA5A5_A5A5);

        // 4: issue sets busy next cycle, writeback clears it
        issue_valid = 1'b1;
        issue_addr  = 5'd9;
        raddr1      = 5'd9;
        raddr2      = 5'd5;
        #1;
        check("issue_same_cycle", 32'(busy1_b), 32'd0);
        tick();
        issue_valid = 1'b0;
        #1;
        check("busy9", 32'(busy1_b), 32'd1);
        check("busy9_nb", 32'(busy1_n), 32'd1);
        check("busy5_other", 32'(busy2_b), 32'd0);
        tick();
        check("busy9_hold", 32'(busy1_b), 32'd1);
        we    = 1'b1;
        waddr = 5'd9;
        wdata = 32'h0000_0099;
        #1;
        check("busy9_byp_clear", 32'(busy1_b), 32'd0);
        check("busy9_nobyp", 32'(busy1_n), 32'd1);
        check("rd9_byp", rdata1_b, 32'h0000_0099);
        tick();
        we = 1'b0;
        #1;
        check("pending9_cleared", 32'(busy1_b), 32'd0);
        check("pending9_cleared_nb", 32'(busy1_n), 32'd0);

        // 5: issue and write same register same cycle, issue to entry 0
        issue_valid = 1'b1;
        issue_addr  = 5'd9;
        we          = 1'b1;
        waddr       = 5'd9;
        wdata       = 32'h0000_0042;
        tick();
        issue_valid = 1'b0;
        we          = 1'b0;
        #1;
        check("set_wins", 32'(busy1_b), 32'd1);
        check("set_wins_nb", 32'(busy1_n), 32'd1);
        check("set_wins_data", rdata1_b, 32'h0000_0042);
        issue_valid = 1'b1;
        issue_addr  = 5'd0;
        raddr2      = 5'd0;
        tick();
        issue_valid = 1'b0;
        #1;
        check("issue0_busy", 32'(busy2_b), 32'd0);
        check("issue0_busy_nb", 32'(busy2_n), 32'd0);

        // 6: reset in READY with pending bits, then reset mid-sweep
        issue_valid = 1'b1;
        issue_addr  = 5'd10;
        tick();
        issue_valid = 1'b0;
        raddr2      = 5'd10;
        #1;
        check("busy10_pre", 32'(busy2_b), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rst_ready_clr", 32'(ready_b), 32'd0);
        check("rst_busy_clr", 32'(busy1_b), 32'd0);
        check("rst_rdata_clr", rdata1_b, 32'h0);
        repeat (12) tick();
        check("mid_sweep_ready", 32'(ready_b), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_ready(lat);
        check("restart_latency", 32'(lat), 32'd32);
        check("restart_ready_nb", 32'(ready_n), 32'd1);
        raddr1 = 5'd9;
        raddr2 = 5'd10;
        #1;
        check("post_rst_busy9", 32'(busy1_b), 32'd0);
        check("post_rst_busy10", 32'(busy2_b), 32'd0);
        check("post_rst_mem9", rdata1_b, 32'h0);
        raddr1 = 5'd5;
        #1;
        check("post_rst_mem5", rdata1_n, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
